pulse_program_sequencer: RTL and testbench
==========================================

# pulse_program_sequencer

Plays a short stored program of mark/space symbols onto a single registered output, `pulse_out`, for the pulse transmitter peripheral. Software loads up to DEPTH symbols while the block is idle, then issues `start`. Each symbol is a level plus a duration in prescaled ticks. `pulse_out` feeds the downstream falling-edge detector stage, which generates the per-mark end event, so `pulse_out` is glitch-free and changes only on clock edges.

## Interface
- DURATION_WIDTH, 8: width of the symbol duration field.
- DEPTH, 4: number of program entries; power of two, at least 2.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  append `wr_data` to the program; accepted only in IDLE.
- wr_data  in  DURATION_WIDTH+1  bit [DURATION_WIDTH] is the level; bits [DURATION_WIDTH-1:0] are duration N.
- clear  in  1  empty the program; accepted only in IDLE.
- start  in  1  begin playback; accepted only in IDLE with length>0.
- stop  in  1  abort playback.
- prescale  in  8  tick period minus one, in clk cycles; sampled every cycle.
- idle_level  in  1  output level while not playing.
- loop  in  1  replay continuously; present only with PULSE_SEQ_LOOP_EN.
- pulse_out  out  1  registered waveform output.
- busy  out  1  high in RUN.
- symbol_done  out  1  one-cycle pulse on the last cycle of each symbol.
- done  out  1  one-cycle pulse when a program completes naturally.
- full  out  1  length == DEPTH.
- length  out  $clog2(DEPTH)+1  number of stored entries.

## Operation
- Storage: DEPTH-entry register array with write index = `length`.
  - `wr_en` in IDLE with length<DEPTH stores the entry and increments `length`.
  - `wr_en` when full, or while busy, is ignored.
- `clear` in IDLE sets length to 0. `clear` while busy is ignored. Entry contents are not reset.
- States: IDLE and RUN.
- IDLE to RUN: on `start` with length>0 and no `stop`. Read index = 0, prescale counter = 0, tick counter = 0.
- In RUN, each symbol lasts (N+1)*(prescale+1) clk cycles at its level. On the last cycle, `symbol_done` = 1 and the read index advances.
- After the last entry (index length-1), the block returns to IDLE and pulses `done`.
- `stop` in RUN: return to IDLE next cycle, with no `done` and no `symbol_done`.
- Priority within one cycle: reset > stop > start > clear > wr_en.
  - `start` with `wr_en` or `clear` in the same cycle: the start is taken and the other is ignored.
  - `start` while busy is ignored.
- Counters saturate nowhere. The tick counter is DURATION_WIDTH bits wide, so the maximum symbol is 2^DURATION_WIDTH ticks.

## Timing
- Reset values: pulse_out=0, busy=0, symbol_done=0, done=0, length=0, state IDLE.
- `start` sampled at edge k:
  - `busy` = 1 and `pulse_out` = level of entry 0 from edge k+1.
  - Entry 0 holds for exactly (N0+1)*(prescale+1) cycles.
- Symbol boundaries:
  - `symbol_done` is high during the final cycle of each symbol.
  - The next level appears on the following edge.
  - There is no gap cycle between symbols.
- End of program: `done` and the final `symbol_done` are high in the same cycle. On the next edge, `busy` = 0 and `pulse_out` = idle_level.
- In IDLE, `pulse_out` follows `idle_level` with one cycle of latency.
- `stop` at edge k: `busy` = 0 and `pulse_out` = idle_level from edge k+1.
- Mid-run reset: all outputs return to reset values on the next edge. The program is lost (length=0).
- Changing `prescale` mid-symbol takes effect at the next tick-counter compare. No retiming is required.

## Configuration
- PULSE_SEQ_LOOP_EN defined:
  - The `loop` port exists.
  - With loop=1 at the end of the last entry, the read index wraps to 0 and playback continues with no gap cycle.
  - `symbol_done` still pulses at the wrap; `done` does not.
  - Looping ends only via `stop` or reset.
  - If `loop` is deasserted mid-run, the program finishes at its next end.
- PULSE_SEQ_LOOP_EN not defined: no `loop` port, and behaviour is single-shot as described above.

## Test plan
- Reset, then idle_level=1: pulse_out=0 during reset; pulse_out=1 one cycle after release; busy=0; length=0.
- Load {1,N=2},{0,N=0} with prescale=1, then start: pulse_out=1 for 6 cycles, then 0 for 2 cycles. symbol_done pulses at cycles 6 and 8 after start. done coincides with the second. Next cycle: busy=0 and pulse_out=idle_level.
- Write 5 entries with DEPTH=4: full=1 and length=4, fifth write dropped. start with length=0 after clear: busy stays 0.
- Stop mid-symbol 0: busy=0 and pulse_out=idle_level next cycle. No done. Program retained, and a restart replays from entry 0.
- Same-cycle start+stop in IDLE: no state change. start while busy: no effect on the waveform. wr_en while busy: length unchanged.
- With PULSE_SEQ_LOOP_EN, loop=1, program {1,N=0},{0,N=0}, prescale=0: output alternates 1,0,1,0 with no gap for at least 3 cycles of the program. done is never pulsed. After loop=0, exactly one done occurs.

Source files
------------

// File: rtl/pulse_program_sequencer.sv
// pulse_program_sequencer: plays a stored program of mark/space symbols onto a
// single registered output. Software loads up to DEPTH {level, duration}
// entries while the block is idle, then issues start. Each symbol holds its
// level for (N+1)*(prescale+1) clk cycles.
//
// Optional feature: define PULSE_SEQ_LOOP_EN to add the loop_i port, which
// replays the program continuously until stop or reset.

module pulse_program_sequencer #(
  parameter int unsigned DURATION_WIDTH = 8,
  parameter int unsigned DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en_i,
  input  logic [DURATION_WIDTH:0]   wr_data_i,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [7:0]                prescale_i,
  input  logic                      idle_level_i,
`ifdef PULSE_SEQ_LOOP_EN
  input  logic                      loop_i,
`endif
  output logic                      pulse_out_o,
  output logic                      busy_o,
  output logic                      symbol_done_o,
  output logic                      done_o,
  output logic                      full_o,
  output logic [$clog2(DEPTH):0]    length_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LenW  = AddrW + 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e                    state_q, state_d;
  logic [DURATION_WIDTH:0]   mem_q [DEPTH];
  logic [LenW-1:0]           len_q, len_d;
  logic [AddrW-1:0]          rd_idx_q, rd_idx_d;
  logic [7:0]                presc_q, presc_d;
  logic [DURATION_WIDTH-1:0] tick_q, tick_d;
  logic                      pulse_q, pulse_d;
  logic                      mem_we;
  logic                      symbol_done;
  logic                      done;
  logic                      loop_en;

  // Fields of the current, following and first program entries.
  logic [DURATION_WIDTH-1:0] cur_n;
  logic                      nxt_level;
  logic                      first_level;
  logic                      tick_end;
  logic                      last_entry;
  logic                      is_full;

`ifdef PULSE_SEQ_LOOP_EN
  assign loop_en = loop_i;
`else
  assign loop_en = 1'b0;
`endif

  assign cur_n       = mem_q[rd_idx_q][DURATION_WIDTH-1:0];
  assign nxt_level   = mem_q[rd_idx_q + AddrW'(1)][DURATION_WIDTH];
  assign first_level = mem_q[0][DURATION_WIDTH];
  // Prescale is compared live, so a mid-symbol change applies at the next compare.
  assign tick_end    = (presc_q == prescale_i);
  assign last_entry  = ((LenW'(rd_idx_q) + LenW'(1)) == len_q);
  assign is_full     = (len_q == LenW'(DEPTH));

  // Next-state, storage control and per-cycle event decode.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_idx_d    = rd_idx_q;
    presc_d     = presc_q;
    tick_d      = tick_q;
    pulse_d     = pulse_q;
    mem_we      = 1'b0;
    symbol_done = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        pulse_d = idle_level_i;
        // Priority: stop > start > clear > wr_en; a higher command masks the rest.
        if (stop_i) begin
          state_d = StIdle;
        end else if (start_i && (len_q != '0)) begin
          state_d  = StRun;
          rd_idx_d = '0;
          presc_d  = '0;
          tick_d   = '0;
          pulse_d  = first_level;
        end else if (clear_i) begin
          len_d = '0;
        end else if (wr_en_i && !is_full) begin
          mem_we = 1'b1;
          len_d  = len_q + LenW'(1);
        end
      end

      StRun: begin
        if (stop_i) begin
          // Abort: no symbol_done/done for the symbol in flight.
          state_d = StIdle;
          pulse_d = idle_level_i;
        end else if (tick_end) begin
          presc_d = '0;
          if (tick_q == cur_n) begin
            symbol_done = 1'b1;
            tick_d      = '0;
            if (last_entry) begin
              if (loop_en) begin
                rd_idx_d = '0;
                pulse_d  = first_level;
              end else begin
                done    = 1'b1;
                state_d = StIdle;
                pulse_d = idle_level_i;
              end
            end else begin
              rd_idx_d = rd_idx_q + AddrW'(1);
              pulse_d  = nxt_level;
            end
          end else begin
            tick_d = tick_q + DURATION_WIDTH'(1);
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control state with synchronous active-low reset; reset discards the program.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      rd_idx_q <= '0;
      presc_q  <= '0;
      tick_q   <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_idx_q <= rd_idx_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      pulse_q  <= pulse_d;
    end
  end

  // Program storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[len_q[AddrW-1:0]] <= wr_data_i;
    end
  end

  assign pulse_out_o   = pulse_q;
  assign busy_o        = (state_q == StRun);
  // Events are masked while reset is asserted so nothing downstream sees a stray pulse.
  assign symbol_done_o = symbol_done & rst_n;
  assign done_o        = done & rst_n;
  assign full_o        = is_full;
  assign length_o      = len_q;

endmodule

// File: tb/tb_pulse_program_sequencer.sv
// Directed self-checking bench for pulse_program_sequencer (DEPTH=4, 8-bit durations).
// The loop scenario is compiled in only when PULSE_SEQ_LOOP_EN is defined.

module tb_pulse_program_sequencer;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [8:0] wr_data;
  logic       clear;
  logic       start;
  logic       stop;
  logic [7:0] prescale;
  logic       idle_level;
`ifdef PULSE_SEQ_LOOP_EN
  logic       loop;
`endif
  logic       pulse_out;
  logic       busy;
  logic       symbol_done;
  logic       done;
  logic       full;
  logic [2:0] length;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  pulse_program_sequencer #(
    .DURATION_WIDTH (8),
    .DEPTH          (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en_i       (wr_en),
    .wr_data_i     (wr_data),
    .clear_i       (clear),
    .start_i       (start),
    .stop_i        (stop),
    .prescale_i    (prescale),
    .idle_level_i  (idle_level),
`ifdef PULSE_SEQ_LOOP_EN
    .loop_i        (loop),
`endif
    .pulse_out_o   (pulse_out),
    .busy_o        (busy),
    .symbol_done_o (symbol_done),
    .done_o        (done),
    .full_o        (full),
    .length_o      (length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [8:0] data);
    wr_en   = 1'b1;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    idle_level = 1'b1;
    step();
    step();
    vectors++;
    if (pulse_out !== 1'b0) begin
      $display("FAIL reset_pulse: got %b expected 0", pulse_out); miscompares++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy: got %b expected 0", busy); miscompares++;
    end
    vectors++;
    if (length !== 3'd0) begin
      $display("FAIL reset_length: got %0d expected 0", length); miscompares++;
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (pulse_out !== 1'b1) begin
      $display("FAIL release_pulse: got %b expected 1", pulse_out); miscompares++;
    end
    vectors++;
    if (busy !== 1'b0 || full !== 1'b0 || length !== 3'd0) begin
      $display("FAIL release_status: busy=%b full=%b len=%0d expected 0/0/0",
               busy, full, length);
      miscompares++;
    end
  endtask

  // {1,N=2},{0,N=0}, prescale=1: six cycles high, two low, idle high afterwards.
  task automatic test_program();
    logic exp_pulse, exp_sd, exp_done, exp_busy;
    prescale   = 8'd1;
    idle_level = 1'b1;
    write_entry(9'h102);
    write_entry(9'h000);
    vectors++;
    if (length !== 3'd2) begin
      $display("FAIL prog_length: got %0d expected 2", length); miscompares++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      exp_pulse = (i <= 6) ? 1'b1 : ((i <= 8) ? 1'b0 : 1'b1);
      exp_sd    = (i == 6) || (i == 8);
      exp_done  = (i == 8);
      exp_busy  = (i <= 8);
      vectors++;
      if (pulse_out !== exp_pulse) begin
        $display("FAIL prog_pulse c%0d: got %b expected %b", i, pulse_out, exp_pulse);
        miscompares++;
      end
      vectors++;
      if (symbol_done !== exp_sd) begin
        $display("FAIL prog_symdone c%0d: got %b expected %b", i, symbol_done, exp_sd);
        miscompares++;
      end
      vectors++;
      if (done !== exp_done) begin
        $display("FAIL prog_done c%0d: got %b expected %b", i, done, exp_done);
        miscompares++;
      end
      vectors++;
      if (busy !== exp_busy) begin
        $display("FAIL prog_busy c%0d: got %b expected %b", i, busy, exp_busy);
        miscompares++;
      end
      if (i < 9) step();
    end
  endtask

  task automatic test_full_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++;
    if (length !== 3'd0 || full !== 1'b0) begin
      $display("FAIL clear_len: len=%0d full=%b expected 0/0", length, full); miscompares++;
    end
    for (int i = 0; i < 5; i++) write_entry(9'(9'h101 + i));
    vectors++;
    if (length !== 3'd4) begin
      $display("FAIL full_length: got %0d expected 4", length); miscompares++;
    end
    vectors++;
    if (full !== 1'b1) begin
      $display("FAIL full_flag: got %b expected 1", full); miscompares++;
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL empty_start: busy=%b expected 0", busy); miscompares++;
    end
    step();
    vectors++;
    if (busy !== 1'b0 || pulse_out !== 1'b1) begin
      $display("FAIL empty_start_hold: busy=%b pulse=%b expected 0/1", busy, pulse_out);
      miscompares++;
    end
  endtask

  // {1,N=5},{0,N=0}, prescale=0, idle low.
  task automatic test_stop();
    int d0;
    prescale   = 8'd0;
    idle_level = 1'b0;
    write_entry(9'h105);
    write_entry(9'h000);
    start = 1'b1;
    step();
    start = 1'b0;
    d0 = done_cnt;
    vectors++;
    if (busy !== 1'b1 || pulse_out !== 1'b1) begin
      $display("FAIL stop_run: busy=%b pulse=%b expected 1/1", busy, pulse_out); miscompares++;
    end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || pulse_out !== 1'b0) begin
      $display("FAIL stop_idle: busy=%b pulse=%b expected 0/0", busy, pulse_out);
      miscompares++;
    end
    step();
    vectors++;
    if (done_cnt !== d0) begin
      $display("FAIL stop_nodone: got %0d dones expected 0", done_cnt - d0); miscompares++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || pulse_out !== 1'b1 || length !== 3'd2) begin
      $display("FAIL restart: busy=%b pulse=%b len=%0d expected 1/1/2", busy, pulse_out, length);
      miscompares++;
    end
    repeat (5) step();
    vectors++;
    if (pulse_out !== 1'b1 || symbol_done !== 1'b1) begin
      $display("FAIL restart_sym0_end: pulse=%b sd=%b expected 1/1", pulse_out, symbol_done);
      miscompares++;
    end
    step();
    vectors++;
    if (pulse_out !== 1'b0 || done !== 1'b1) begin
      $display("FAIL restart_done: pulse=%b done=%b expected 0/1", pulse_out, done);
      miscompares++;
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL restart_end: busy=%b expected 0", busy); miscompares++;
    end
  endtask

  task automatic test_ignore();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    vectors++;
    if (busy !== 1'b0 || length !== 3'd2) begin
      $display("FAIL start_stop_idle: busy=%b len=%0d expected 0/2", busy, length);
      miscompares++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start   = 1'b1;
    wr_en   = 1'b1;
    clear   = 1'b1;
    wr_data = 9'h1ff;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    clear = 1'b0;
    vectors++;
    if (busy !== 1'b1 || pulse_out !== 1'b1 || symbol_done !== 1'b0) begin
      $display("FAIL busy_cmds: busy=%b pulse=%b sd=%b expected 1/1/0", busy, pulse_out,
               symbol_done);
      miscompares++;
    end
    vectors++;
    if (length !== 3'd2) begin
      $display("FAIL busy_write: len=%0d expected 2", length); miscompares++;
    end
    repeat (3) step();
    vectors++;
    if (symbol_done !== 1'b1 || done !== 1'b0) begin
      $display("FAIL busy_sym0_end: sd=%b done=%b expected 1/0", symbol_done, done);
      miscompares++;
    end
    step();
    vectors++;
    if (done !== 1'b1 || pulse_out !== 1'b0) begin
      $display("FAIL busy_done: done=%b pulse=%b expected 1/0", done, pulse_out); miscompares++;
    end
    step();
  endtask

  task automatic test_midrun_reset();
    idle_level = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      $display("FAIL mrst_run: busy=%b expected 1", busy); miscompares++;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || pulse_out !== 1'b0 || length !== 3'd0 || done !== 1'b0) begin
      $display("FAIL mrst_state: busy=%b pulse=%b len=%0d done=%b expected 0/0/0/0",
               busy, pulse_out, length, done);
      miscompares++;
    end
    step();
    vectors++;
    if (pulse_out !== 1'b1) begin
      $display("FAIL mrst_idle: pulse=%b expected 1", pulse_out); miscompares++;
    end
  endtask

`ifdef PULSE_SEQ_LOOP_EN
  task automatic test_loop();
    int   d0;
    logic exp_pulse;
    prescale = 8'd0;
    write_entry(9'h100);
    write_entry(9'h000);
    loop  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    d0 = done_cnt;
    for (int i = 1; i <= 8; i++) begin
      exp_pulse = i[0];
      vectors++;
      if (pulse_out !== exp_pulse || symbol_done !== 1'b1 || done !== 1'b0) begin
        $display("FAIL loop c%0d: pulse=%b sd=%b done=%b expected %b/1/0", i, pulse_out,
                 symbol_done, done, exp_pulse);
        miscompares++;
      end
      step();
    end
    loop = 1'b0;
    vectors++;
    if (pulse_out !== 1'b1 || done_cnt !== d0) begin
      $display("FAIL loop_wrap: pulse=%b dones=%0d expected 1/0", pulse_out, done_cnt - d0);
      miscompares++;
    end
    step();
    vectors++;
    if (pulse_out !== 1'b0 || done !== 1'b1) begin
      $display("FAIL loop_exit: pulse=%b done=%b expected 0/1", pulse_out, done); miscompares++;
    end
    step();
    vectors++;
    if (busy !== 1'b0 || pulse_out !== 1'b1 || done_cnt - d0 !== 1) begin
      $display("FAIL loop_end: busy=%b pulse=%b dones=%0d expected 0/1/1", busy, pulse_out,
               done_cnt - d0);
      miscompares++;
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    clear      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    prescale   = '0;
    idle_level = 1'b1;
`ifdef PULSE_SEQ_LOOP_EN
    loop       = 1'b0;
`endif
    test_reset();
    test_program();
    test_full_clear();
    test_stop();
    test_ignore();
    test_midrun_reset();
`ifdef PULSE_SEQ_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
